// File: rtl/grant_sequencer8.sv
// Round-robin request/grant controller for 8 clients: registered one-hot grant held across a transfer.
// Optional hold-timeout force-release is enabled with `define GRANT_SEQUENCER8_TIMEOUT_EN.
module grant_sequencer8 #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N-1:0]         REQ,
    input  logic                 DONE,
    output logic [N-1:0]         GNT,
    output logic                 GNT_VALID,
    output logic [$clog2(N)-1:0] GNT_IDX,
    output logic                 TIMEOUT
);

    localparam int IDX_W = $clog2(N);

    if (N != 8) begin : g_bad_n
        $error("grant_sequencer8 supports only N = 8");
    end

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("grant_sequencer8 HOLD_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic [N-1:0]       shifted_last;
    logic [N-1:0]       above_mask;
    logic [N-1:0]       masked_req;
    logic [N-1:0]       pick_src;
    logic [N-1:0]       winner_oh;
    logic [IDX_W-1:0]   winner_idx;
    logic               release_req;

`ifdef GRANT_SEQUENCER8_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    // Priority starts just above the previous winner and wraps to the lowest requester.
    always_comb begin
        shifted_last = N'(2) << last_q;
        above_mask   = ~(shifted_last - N'(1));
        masked_req   = REQ & above_mask;
        pick_src     = (masked_req != '0) ? masked_req : REQ;
        winner_oh    = pick_src & ~(pick_src - N'(1));
        winner_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (winner_oh[i]) begin
                winner_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        last_d      = last_q;
        release_req = DONE || !REQ[gnt_idx_q];
`ifdef GRANT_SEQUENCER8_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            IDLE, RELEASE: begin
                gnt_d = '0;
                if (REQ != '0) begin
                    gnt_d     = winner_oh;
                    gnt_idx_d = winner_idx;
                    last_d    = winner_idx;
                    state_d   = GRANT;
`ifdef GRANT_SEQUENCER8_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            GRANT: begin
                // A genuine release always wins over the timeout, so TIMEOUT never pulses with DONE.
                if (release_req) begin
                    gnt_d   = '0;
                    state_d = RELEASE;
`ifdef GRANT_SEQUENCER8_TIMEOUT_EN
                end else if (hold_cnt_q == HOLD_LAST) begin
                    gnt_d     = '0;
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= IDX_W'(N - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
        end
    end

`ifdef GRANT_SEQUENCER8_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT       = gnt_q;
    assign GNT_VALID = |gnt_q;
    assign GNT_IDX   = gnt_idx_q;

endmodule

// File: tb/tb_grant_sequencer8.sv
// Self-checking bench for grant_sequencer8: vector table, directed corner sequences and random
// stimulus against a round-robin reference model.
module tb_grant_sequencer8;

    localparam int HOLD_MAX = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] REQ = 8'h00;
    logic       DONE = 1'b0;
    logic [7:0] GNT;
    logic       GNT_VALID;
    logic [2:0] GNT_IDX;
    logic       TIMEOUT;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: who owns the resource, how long it has held it, and who won last.
    int mOwner = -1;
    int mLast  = 7;
    int mIdx   = 0;
    int mHeld  = 0;
    bit mTo    = 1'b0;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       rst;
        logic [7:0] expGnt;
        logic [2:0] expIdx;
        logic       expTo;
    } vec_t;

    vec_t vecs[17];

    always #5 CLK = ~CLK;

    grant_sequencer8 #(
        .N        (8),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .DONE      (DONE),
        .GNT       (GNT),
        .GNT_VALID (GNT_VALID),
        .GNT_IDX   (GNT_IDX),
        .TIMEOUT   (TIMEOUT)
    );

    function automatic int pickWinner(input logic [7:0] req, input int last);
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (last + k) % 8;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic [7:0] req, input logic done, input logic rst);
        if (rst) begin
            mOwner = -1;
            mLast  = 7;
            mIdx   = 0;
            mHeld  = 0;
            mTo    = 1'b0;
        end else if (mOwner >= 0) begin
            mHeld = mHeld + 1;
            mTo   = 1'b0;
            if (done || !req[mOwner]) begin
                mOwner = -1;
            end
`ifdef GRANT_SEQUENCER8_TIMEOUT_EN
            else if (mHeld >= HOLD_MAX) begin
                mOwner = -1;
                mTo    = 1'b1;
            end
`endif
        end else begin
            mTo = 1'b0;
            if (req != 8'h00) begin
                mOwner = pickWinner(req, mLast);
                mIdx   = mOwner;
                mLast  = mOwner;
                mHeld  = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic done, input logic rst);
        REQ   = req;
        DONE  = done;
        RESET = rst;
        @(posedge CLK);
        modelStep(req, done, rst);
        #1;
    endtask

    task automatic checkOutput(input string name);
        logic [7:0]  eg;
        logic [12:0] act;
        logic [12:0] exp;
        eg = 8'h00;
        if (mOwner >= 0) eg[mOwner] = 1'b1;
        act = {GNT, GNT_VALID, GNT_IDX, TIMEOUT};
        exp = {eg, |eg, 3'(mIdx), mTo};
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s (model): got gnt=%h valid=%b idx=%0d to=%b, want gnt=%h valid=%b idx=%0d to=%b",
                     name, GNT, GNT_VALID, GNT_IDX, TIMEOUT, eg, |eg, mIdx, mTo);
        end
    endtask

    task automatic checkConst(input string name, input logic [7:0] eg, input logic [2:0] ei, input logic et);
        logic [12:0] act;
        logic [12:0] exp;
        act = {GNT, GNT_VALID, GNT_IDX, TIMEOUT};
        exp = {eg, |eg, ei, et};
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got gnt=%h valid=%b idx=%0d to=%b, want gnt=%h valid=%b idx=%0d to=%b",
                     name, GNT, GNT_VALID, GNT_IDX, TIMEOUT, eg, |eg, ei, et);
        end
    endtask

    initial begin
        logic [7:0] rq;
        logic       dn;
        logic       rs;
        logic [7:0] expGnt;
        int         expIdx;
        int         perIdx[8];

        //              req    done  rst   gnt    idx  to
        vecs[0]  = '{8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[3]  = '{8'h0A, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0};
        vecs[4]  = '{8'h0A, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0};
        vecs[5]  = '{8'h0A, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0};
        vecs[6]  = '{8'h0A, 1'b0, 1'b0, 8'h08, 3'd3, 1'b0};
        vecs[7]  = '{8'h0A, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0};
        vecs[8]  = '{8'h0A, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vecs[10] = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vecs[11] = '{8'h20, 1'b0, 1'b0, 8'h20, 3'd5, 1'b0};
        vecs[12] = '{8'h21, 1'b0, 1'b0, 8'h20, 3'd5, 1'b0};
        vecs[13] = '{8'h01, 1'b0, 1'b0, 8'h00, 3'd5, 1'b0};
        vecs[14] = '{8'h01, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0};
        vecs[15] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};

        for (int v = 0; v < 17; v++) begin
            applyStimulus(vecs[v].req, vecs[v].done, vecs[v].rst);
            checkConst($sformatf("vec%0d", v), vecs[v].expGnt, vecs[v].expIdx, vecs[v].expTo);
            checkOutput($sformatf("vec%0d", v));
        end

        // Reset idle window.
        applyStimulus(8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(8'h00, 1'b0, 1'b0);
            checkConst("idle_after_reset", 8'h00, 3'd0, 1'b0);
        end

        // Two requesters, DONE three cycles after each grant.
        applyStimulus(8'h0A, 1'b0, 0);
        expGnt = 8'h02;
        checkConst("rr_first", expGnt, 3'd1, 1'b0);
        for (int g = 0; g < 4; g++) begin
            applyStimulus(8'h0A, 1'b0, 1'b0);
            checkConst("rr_hold", expGnt, (expGnt == 8'h02) ? 3'd1 : 3'd3, 1'b0);
            applyStimulus(8'h0A, 1'b0, 1'b0);
            checkConst("rr_hold", expGnt, (expGnt == 8'h02) ? 3'd1 : 3'd3, 1'b0);
            applyStimulus(8'h0A, 1'b1, 1'b0);
            checkConst("rr_gap", 8'h00, (expGnt == 8'h02) ? 3'd1 : 3'd3, 1'b0);
            applyStimulus(8'h0A, 1'b0, 1'b0);
            expGnt = (expGnt == 8'h02) ? 8'h08 : 8'h02;
            checkConst("rr_next", expGnt, (expGnt == 8'h02) ? 3'd1 : 3'd3, 1'b0);
        end

        // All eight requesting: strict rotation, one grant per client per eight grants.
        applyStimulus(8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) perIdx[i] = 0;
        applyStimulus(8'hFF, 1'b0, 1'b0);
        expIdx = 0;
        for (int g = 0; g < 16; g++) begin
            checkConst("ff_grant", 8'(1 << expIdx), 3'(expIdx), 1'b0);
            perIdx[GNT_IDX]++;
            applyStimulus(8'hFF, 1'b0, 1'b0);
            checkOutput("ff_hold");
            applyStimulus(8'hFF, 1'b1, 1'b0);
            checkConst("ff_gap", 8'h00, 3'(expIdx), 1'b0);
            applyStimulus(8'hFF, 1'b0, 1'b0);
            expIdx = (expIdx + 1) % 8;
        end
        for (int i = 0; i < 8; i++) begin
            assertCount++;
            if (perIdx[i] != 2) begin
                failCount++;
                $display("[TB] FAIL ff_fairness idx%0d: got %0d grants, want 2", i, perIdx[i]);
            end
        end

        // Reset while client 4 holds the grant, with DONE in flight.
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkConst("rst_pre", 8'h10, 3'd4, 1'b0);
        applyStimulus(8'h10, 1'b1, 1'b1);
        checkConst("rst_mid_grant", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h11, 1'b0, 1'b0);
        checkConst("rst_then_first", 8'h01, 3'd0, 1'b0);

        // Single requester that never finishes.
        applyStimulus(8'h00, 1'b0, 1'b1);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkConst("hold_c1", 8'h04, 3'd2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(8'h04, 1'b0, 1'b0);
            checkConst("hold_c2to4", 8'h04, 3'd2, 1'b0);
        end
`ifdef GRANT_SEQUENCER8_TIMEOUT_EN
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkConst("timeout_pulse", 8'h00, 3'd2, 1'b1);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkConst("timeout_regrant", 8'h04, 3'd2, 1'b0);
`else
        for (int c = 0; c < 100; c++) begin
            applyStimulus(8'h04, 1'b0, 1'b0);
            checkConst("hold_forever", 8'h04, 3'd2, 1'b0);
        end
`endif

        // Randomized traffic against the model.
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("rand_reset");
        rq = 8'h00;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
            else if ($urandom_range(0, 4) == 0) rq = rq & ~(8'h01 << $urandom_range(0, 7));
            dn = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 59) == 0);
            applyStimulus(rq, dn, rs);
            checkOutput("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
